// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arb_pkg
// Purpose  : Shared types and constants for the camera I2C bus arbiter.
// Revision : 1.0
// ============================================================================
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    localparam int REQ_NIOS = 0;
    localparam int REQ_AF   = 1;
    localparam int CNT_W    = 24;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arb_timer
// Purpose  : Loadable down-counter with zero flag, shared by guard and timeout.
// Revision : 1.0
// ============================================================================
module i2c_arb_timer
    import i2c_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Decrement only while non-zero so the count can never wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : i2c_arb_timer
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Round-robin owner arbitration of a shared open-drain I2C bus.
// Revision : 1.0
// ============================================================================
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int GUARD_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_req_scl_oe,
    input  logic [1:0] i_req_sda_oe,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic [1:0] o_gnt,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] c_GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    logic             r_owner;
    logic             r_last;
    logic [1:0]       r_blocked;
    logic [1:0]       r_gnt;
    logic             r_scl_oe;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_timeout;

    logic [1:0]       w_elig;
    logic             w_bus_idle;
    logic             w_grant;
    logic             w_pick;
    logic             w_owner_req;
    logic             w_zero;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;

    assign w_elig      = i_req & ~r_blocked;
    assign w_bus_idle  = i_scl & i_sda;
    assign w_grant     = (w_elig != 2'b00) && w_bus_idle;
    // Both eligible: the one that did not own the bus last time wins.
    assign w_pick      = (w_elig == 2'b11) ? ~r_last : w_elig[REQ_AF];
    assign w_owner_req = i_req[r_owner];

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_load     = 1'b1;
                    w_load_val = c_TIMEOUT_LOAD;
                end
            end
            OWN: begin
                if (!w_owner_req || w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_GUARD_LOAD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            GUARD:   w_dec = 1'b1;
            default: w_dec = 1'b0;
        endcase
    end

    i2c_arb_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_blocked <= 2'b00;
            r_gnt     <= 2'b00;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_blocked <= r_blocked & i_req;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_gnt   <= 2'b01 << w_pick;
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_busy  <= 1'b1;
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (!w_owner_req) begin
                        r_gnt    <= 2'b00;
                        r_scl_oe <= 1'b0;
                        r_sda_oe <= 1'b0;
                        r_state  <= GUARD;
                    end else if (w_zero) begin
                        // Revoked owner stays locked out until it drops req.
                        r_gnt     <= 2'b00;
                        r_scl_oe  <= 1'b0;
                        r_sda_oe  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_blocked <= (r_blocked & i_req) | (2'b01 << r_owner);
                        r_state   <= GUARD;
                    end else begin
                        r_scl_oe <= i_req_scl_oe[r_owner];
                        r_sda_oe <= i_req_sda_oe[r_owner];
                    end
                end
                GUARD: begin
                    if (w_zero) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_scl_oe  = r_scl_oe;
    assign o_sda_oe  = r_sda_oe;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule : i2c_bus_arbiter
`default_nettype wire
